// File: rtl/malvar_he_cutler_demosaic_pipe.sv
// Malvar-He-Cutler gradient-corrected demosaicer: 5x5 RGGB window in, one 24-bit RGB pixel out.
// Define MHC_DEMOSAIC_PIPELINE_EN to register the kernel sums (latency 2 instead of 1).
module malvar_he_cutler_demosaic_pipe (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [0:4][0:4][7:0]  pixel_matrix,
  input  logic [0:4]            pixel_row_enable,
  input  logic [0:4]            pixel_column_enable,
  input  logic [1:0]            center_pixel_type,
  output logic                  out_valid,
  output logic [23:0]           center_pixel_rgb
);

  logic [2:0]         row_src [5];
  logic [2:0]         col_src [5];
  logic               row_ctr [5];
  logic               col_ctr [5];
  logic signed [15:0] w [5][5];

  // Mirror across the centre first; fall back to row/col 2 (even, parity-safe) or the centre tap.
  // The generic form also covers index 2, which always resolves to itself.
  for (genvar gi = 0; gi < 5; gi++) begin : g_sub
    assign row_src[gi] = pixel_row_enable[gi] ? 3'(gi) :
                         (pixel_row_enable[4-gi] ? 3'(4-gi) : 3'd2);
    assign col_src[gi] = pixel_column_enable[gi] ? 3'(gi) :
                         (pixel_column_enable[4-gi] ? 3'(4-gi) : 3'd2);
    assign row_ctr[gi] = !pixel_row_enable[gi] && !pixel_row_enable[4-gi] && (gi % 2 == 1);
    assign col_ctr[gi] = !pixel_column_enable[gi] && !pixel_column_enable[4-gi] && (gi % 2 == 1);
  end

  // Only taps within squared distance 4 of the centre feed any kernel.
  for (genvar gi = 0; gi < 5; gi++) begin : g_row
    for (genvar gj = 0; gj < 5; gj++) begin : g_col
      if ((gi - 2) * (gi - 2) + (gj - 2) * (gj - 2) <= 4) begin : g_tap
        assign w[gi][gj] = (row_ctr[gi] || col_ctr[gj]) ? {8'd0, pixel_matrix[2][2]}
                         : {8'd0, pixel_matrix[row_src[gi]][col_src[gj]]};
      end
    end
  end

  logic signed [15:0] c, ax1, ax2, ns1, ew1, ns2, ew2, dg;
  logic signed [15:0] k_g, k_row, k_col, k_opp, k_nat;

  assign c   = w[2][2];
  assign ns1 = w[1][2] + w[3][2];
  assign ew1 = w[2][1] + w[2][3];
  assign ns2 = w[0][2] + w[4][2];
  assign ew2 = w[2][0] + w[2][4];
  assign ax1 = ns1 + ew1;
  assign ax2 = ns2 + ew2;
  assign dg  = w[1][1] + w[1][3] + w[3][1] + w[3][3];

  assign k_g   = 16'sd8  * c + 16'sd4 * ax1 - 16'sd2 * ax2;
  assign k_row = 16'sd10 * c + 16'sd8 * ew1 - 16'sd2 * ew2 - 16'sd2 * dg + ns2;
  assign k_col = 16'sd10 * c + 16'sd8 * ns1 - 16'sd2 * ns2 - 16'sd2 * dg + ew2;
  assign k_opp = 16'sd12 * c + 16'sd4 * dg  - 16'sd3 * ax2;
  // Native channel goes through the same round/clamp path as 16*centre, which returns it exactly.
  assign k_nat = 16'sd16 * c;

  logic signed [15:0] acc_r, acc_g, acc_b;

  always_comb begin
    acc_r = k_nat;
    acc_g = k_g;
    acc_b = k_opp;
    case (center_pixel_type)
      2'b00: begin acc_r = k_nat; acc_g = k_g;   acc_b = k_opp; end
      2'b01: begin acc_r = k_row; acc_g = k_nat; acc_b = k_col; end
      2'b10: begin acc_r = k_col; acc_g = k_nat; acc_b = k_row; end
      default: begin acc_r = k_opp; acc_g = k_g; acc_b = k_nat; end
    endcase
  end

  logic signed [15:0] sel_r, sel_g, sel_b;
  logic               sel_valid;

`ifdef MHC_DEMOSAIC_PIPELINE_EN
  logic signed [15:0] acc_r_reg, acc_g_reg, acc_b_reg;
  logic               stage_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r_reg       <= '0;
      acc_g_reg       <= '0;
      acc_b_reg       <= '0;
      stage_valid_reg <= 1'b0;
    end else begin
      stage_valid_reg <= in_valid;
      if (in_valid) begin
        acc_r_reg <= acc_r;
        acc_g_reg <= acc_g;
        acc_b_reg <= acc_b;
      end
    end
  end

  assign sel_r     = acc_r_reg;
  assign sel_g     = acc_g_reg;
  assign sel_b     = acc_b_reg;
  assign sel_valid = stage_valid_reg;
`else
  assign sel_r     = acc_r;
  assign sel_g     = acc_g;
  assign sel_b     = acc_b;
  assign sel_valid = in_valid;
`endif

  function automatic logic [7:0] round_clamp(input logic signed [15:0] a);
    logic signed [15:0] s;
    s = (a + 16'sd8) >>> 4;
    if (s < 16'sd0)        return 8'd0;
    else if (s > 16'sd255) return 8'd255;
    else                   return s[7:0];
  endfunction

  logic [23:0] rgb_reg;
  logic        valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_reg   <= 24'h000000;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= sel_valid;
      if (sel_valid)
        rgb_reg <= {round_clamp(sel_r), round_clamp(sel_g), round_clamp(sel_b)};
    end
  end

  assign out_valid        = valid_reg;
  assign center_pixel_rgb = rgb_reg;

endmodule

// File: tb/tb_malvar_he_cutler_demosaic_pipe.sv
// Directed bench for malvar_he_cutler_demosaic_pipe; latency follows MHC_DEMOSAIC_PIPELINE_EN.
module tb_malvar_he_cutler_demosaic_pipe;

`ifdef MHC_DEMOSAIC_PIPELINE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [0:4][0:4][7:0] pm;
  logic [0:4]           row_en;
  logic [0:4]           col_en;
  logic [1:0]           ptype;
  logic                 out_valid;
  logic [23:0]          rgb;

  int checks   = 0;
  int failures = 0;

  malvar_he_cutler_demosaic_pipe dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .pixel_matrix        (pm),
    .pixel_row_enable    (row_en),
    .pixel_column_enable (col_en),
    .center_pixel_type   (ptype),
    .out_valid           (out_valid),
    .center_pixel_rgb    (rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        pm[r][c] = v;
  endtask

  // One pixel in, wait the configured latency, check valid and colour.
  task automatic run(input string tag, input logic [1:0] t, input logic [23:0] exp);
    ptype    = t;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_valid"}, {23'd0, out_valid}, 24'd1);
    check(tag, rgb, exp);
    $display("txn %s type=%0d rgb=%h expected=%h", tag, t, rgb, exp);
  endtask

  initial begin
    int cnt;
    int first;
    reset    = 1'b1;
    in_valid = 1'b0;
    row_en   = 5'b11111;
    col_en   = 5'b11111;
    ptype    = 2'b00;
    set_all(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {23'd0, out_valid}, 24'd0);
    check("reset_rgb", rgb, 24'h000000);
    reset = 1'b0;

    // Gray preservation on every site type
    set_all(8'hAB);
    run("gray_t0", 2'b00, 24'hABABAB);
    run("gray_t1", 2'b01, 24'hABABAB);
    run("gray_t2", 2'b10, 24'hABABAB);
    run("gray_t3", 2'b11, 24'hABABAB);

    // Positive clamp on G: acc 4080
    set_all(8'h00);
    pm[1][2] = 8'hFF; pm[3][2] = 8'hFF; pm[2][1] = 8'hFF; pm[2][3] = 8'hFF;
    run("clamp_hi_g", 2'b00, 24'h00FF00);

    // Centre 255 with distance-2 axis taps 255: G and B sums cancel to 0
    set_all(8'h00);
    pm[2][2] = 8'hFF;
    pm[0][2] = 8'hFF; pm[4][2] = 8'hFF; pm[2][0] = 8'hFF; pm[2][4] = 8'hFF;
    run("clamp_lo_r", 2'b00, 24'hFF0000);

    // Negative sums: G acc -2040, B acc -3060 -> both clamp to 0
    pm[2][2] = 8'h00;
    run("clamp_neg", 2'b00, 24'h000000);

    // Diagonals 255 only: B at R site = 16*255 -> 255
    set_all(8'h00);
    pm[1][1] = 8'hFF; pm[1][3] = 8'hFF; pm[3][1] = 8'hFF; pm[3][3] = 8'hFF;
    run("clamp_hi_b", 2'b00, 24'h0000FF);

    // Rows 0-1 outside the image are mirrored from rows 4/3
    set_all(8'h40);
    for (int c = 0; c < 5; c++) begin pm[0][c] = 8'hFF; pm[1][c] = 8'hFF; end
    row_en = 5'b00111;
    run("bound_rows", 2'b00, 24'h404040);

    // All rows but the centre disabled: rows 0/4 -> row 2, rows 1/3 -> centre
    set_all(8'hFF);
    for (int c = 0; c < 5; c++) pm[2][c] = 8'h40;
    row_en = 5'b00000;
    run("bound_allrows", 2'b01, 24'h404040);

    // Columns 3-4 outside the image are mirrored from columns 1/0
    row_en = 5'b11111;
    set_all(8'h20);
    for (int r = 0; r < 5; r++) begin pm[r][3] = 8'hFF; pm[r][4] = 8'hFF; end
    col_en = 5'b11100;
    run("bound_cols", 2'b10, 24'h202020);
    col_en = 5'b11111;

    // Native pass-through at B site: R=(728+8)>>4=46, G=(1168+8)>>4=73
    set_all(8'h80);
    pm[2][2] = 8'h12;
    run("native_b", 2'b11, 24'h2E4912);

    // Row/column kernel asymmetry at G sites: row sum 160 -> 10, column sum 800 -> 50
    set_all(8'h80);
    pm[2][0] = 8'h40; pm[2][1] = 8'h40; pm[2][3] = 8'h40; pm[2][4] = 8'h40;
    pm[2][2] = 8'h10;
    run("gsite_t1", 2'b01, 24'h0A1032);
    run("gsite_t2", 2'b10, 24'h32100A);

    // Reset mid-stream with in_valid held high
    set_all(8'hAB);
    ptype    = 2'b00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_valid", {23'd0, out_valid}, 24'd0);
    check("midreset_rgb", rgb, 24'h000000);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", {23'd0, out_valid}, 24'd0);
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
    end
    check("flushed_idle", {23'd0, out_valid}, 24'd0);

    // Single in_valid pulse -> exactly one out_valid pulse at the latency
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt   = 0;
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      if (out_valid) begin
        cnt++;
        if (first == 0) first = i;
        check("pulse_rgb", rgb, 24'hABABAB);
      end
      @(posedge clk); #1;
    end
    check("pulse_count", 24'(cnt), 24'd1);
    check("pulse_latency", 24'(first), 24'(LAT));
    $display("txn pulse count=%0d first_cycle=%0d", cnt, first);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
